// File: rtl/com_sequencer.sv
// Command sequencer: buffers commands in a FIFO, issues each as a one-cycle write strobe,
// waits for the per-channel completion, re-issues on timeout and halts on exhausted retries.
module com_sequencer #(
    parameter int NCH       = 4,
    parameter int CMD_W     = 8,
    parameter int DEPTH     = 4,
    parameter int TMO_W     = 8,
    parameter int MAX_RETRY = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [CMD_W-1:0]           cmd_data,
    input  logic [$clog2(NCH)-1:0]     cmd_ch,
    input  logic [TMO_W-1:0]           timeout,
    input  logic [NCH-1:0]             com_end,
    input  logic                       clr_err,
    output logic                       write,
    output logic [CMD_W-1:0]           wr_data,
    output logic [$clog2(NCH)-1:0]     wr_ch,
    output logic                       busy,
    output logic                       err,
    output logic [$clog2(NCH)-1:0]     err_ch,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int CH_W  = $clog2(NCH);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int RTY_W = $clog2(MAX_RETRY + 2);

    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HALT
    } state_t;

    state_t                  r_state;
    logic [CMD_W+CH_W-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [LVL_W-1:0]        r_level;
    logic [CMD_W-1:0]        r_hold_data;
    logic [CH_W-1:0]         r_hold_ch;
    logic [RTY_W-1:0]        r_retry;
    logic [TMO_W-1:0]        r_cnt;
    logic                    r_tmo_en;
    logic                    r_write;
    logic [CMD_W-1:0]        r_wr_data;
    logic [CH_W-1:0]         r_wr_ch;
    logic                    r_busy;
    logic                    r_err;
    logic [CH_W-1:0]         r_err_ch;

    wire w_ready  = (r_level != FULL_LVL);
    wire w_push   = cmd_valid && w_ready;
    wire w_pop    = (r_state == S_IDLE) && !r_err && (r_level != '0);
    wire w_done   = com_end[r_hold_ch];
    wire w_expire = r_tmo_en && (r_cnt == TMO_ONE);

    // Storage needs no reset; emptiness is defined by the pointers and level.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cmd_ch, cmd_data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_hold_data <= '0;
            r_hold_ch   <= '0;
            r_retry     <= '0;
            r_cnt       <= '0;
            r_tmo_en    <= 1'b0;
            r_write     <= 1'b0;
            r_wr_data   <= '0;
            r_wr_ch     <= '0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_err_ch    <= '0;
        end else begin
            r_write <= 1'b0;
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_level <= r_level + LVL_W'(w_push) - LVL_W'(w_pop);

            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        {r_hold_ch, r_hold_data} <= r_mem[r_rd_ptr];
                        r_retry <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_write   <= 1'b1;
                    r_wr_data <= r_hold_data;
                    r_wr_ch   <= r_hold_ch;
                    r_cnt     <= timeout;
                    r_tmo_en  <= (timeout != '0);
                    r_state   <= S_WAIT;
                end
                S_WAIT: begin
                    // Completion is tested first so it wins over a same-cycle expiry.
                    if (w_done) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (w_expire) begin
                        if (r_retry < RTY_MAX) begin
                            r_retry <= r_retry + RTY_W'(1);
                            r_state <= S_ISSUE;
                        end else begin
                            r_err    <= 1'b1;
                            r_err_ch <= r_hold_ch;
                            r_state  <= S_HALT;
                        end
                    end else if (r_tmo_en) begin
                        r_cnt <= r_cnt - TMO_ONE;
                    end
                end
                S_HALT: begin
                    if (clr_err) begin
                        r_err    <= 1'b0;
                        r_err_ch <= '0;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready = w_ready;
    assign write     = r_write;
    assign wr_data   = r_wr_data;
    assign wr_ch     = r_wr_ch;
    assign busy      = r_busy;
    assign err       = r_err;
    assign err_ch    = r_err_ch;
    assign level     = r_level;

endmodule

// File: tb/tb_com_sequencer.sv
// Directed bench for com_sequencer with a write scoreboard and per-step assertions.
module tb_com_sequencer;

    localparam int NCH       = 4;
    localparam int CMD_W     = 8;
    localparam int DEPTH     = 4;
    localparam int TMO_W     = 8;
    localparam int MAX_RETRY = 2;

    logic             clk       = 1'b0;
    logic             reset     = 1'b1;
    logic             cmd_valid = 1'b0;
    logic [CMD_W-1:0] cmd_data  = '0;
    logic [1:0]       cmd_ch    = '0;
    logic [TMO_W-1:0] timeout   = '0;
    logic [NCH-1:0]   com_end   = '0;
    logic             clr_err   = 1'b0;
    logic             cmd_ready;
    logic             write;
    logic [CMD_W-1:0] wr_data;
    logic [1:0]       wr_ch;
    logic             busy;
    logic             err;
    logic [1:0]       err_ch;
    logic [2:0]       level;

    com_sequencer #(
        .NCH(NCH), .CMD_W(CMD_W), .DEPTH(DEPTH), .TMO_W(TMO_W), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_data(cmd_data), .cmd_ch(cmd_ch), .timeout(timeout), .com_end(com_end),
        .clr_err(clr_err), .write(write), .wr_data(wr_data), .wr_ch(wr_ch),
        .busy(busy), .err(err), .err_ch(err_ch), .level(level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CMD_W-1:0] d;
        logic [1:0]       ch;
    } exp_t;

    exp_t sb[$];
    int   wr_cyc[$];
    int   cyc     = 0;
    int   checks  = 0;
    int   errors  = 0;
    logic prev_wr = 1'b0;
    exp_t mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every strobe must match the next expected command and never repeat back to back.
    always @(negedge clk) begin
        if (write === 1'b1) begin
            wr_cyc.push_back(cyc);
            chk("write_gap", {31'd0, prev_wr}, 0);
            if (sb.size() == 0) begin
                chk("unexpected_write", {31'd0, write}, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_wr_data", {24'd0, wr_data}, {24'd0, mon_e.d});
                chk("sb_wr_ch", {30'd0, wr_ch}, {30'd0, mon_e.ch});
            end
        end
        prev_wr = write;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic push(input logic [CMD_W-1:0] d, input logic [1:0] ch, input int copies);
        int   n;
        exp_t e;
        n = 0;
        cmd_valid = 1'b1;
        cmd_data  = d;
        cmd_ch    = ch;
        for (int i = 0; i < copies; i++) begin
            e.d  = d;
            e.ch = ch;
            sb.push_back(e);
        end
        while (cmd_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("push_ready", {31'd0, cmd_ready}, 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_write(input string tag);
        int n;
        n = 0;
        while (write !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, write}, 1);
    endtask

    task automatic complete_next(input logic [1:0] ch);
        wait_write("drain_write");
        tick();
        com_end = 4'(1) << ch;
        tick();
        com_end = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int i0;
        int n0;

        // reset values
        idle(2);
        reset = 1'b0;
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 1);
        chk("rst_write", {31'd0, write}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_err", {31'd0, err}, 0);
        chk("rst_err_ch", {30'd0, err_ch}, 0);
        chk("rst_level", {29'd0, level}, 0);
        chk("rst_wr_data", {24'd0, wr_data}, 0);
        chk("rst_wr_ch", {30'd0, wr_ch}, 0);

        // single command, latency and completion
        timeout = 8'd10;
        push(8'h5A, 2'd2, 1);
        chk("t1_level_after_push", {29'd0, level}, 1);
        chk("t1_write_accept", {31'd0, write}, 0);
        tick();
        chk("t1_write_issue", {31'd0, write}, 0);
        chk("t1_busy_issue", {31'd0, busy}, 1);
        tick();
        chk("t1_write_strobe", {31'd0, write}, 1);
        chk("t1_wr_data", {24'd0, wr_data}, 32'h5A);
        chk("t1_wr_ch", {30'd0, wr_ch}, 2);
        idle(3);
        chk("t1_busy_wait", {31'd0, busy}, 1);
        com_end = 4'b0100;
        tick();
        com_end = '0;
        chk("t1_busy_fall", {31'd0, busy}, 0);
        chk("t1_write_count", wr_cyc.size(), 1);

        // FIFO full with no completions
        timeout = 8'd0;
        push(8'h10, 2'd0, 1);
        push(8'h11, 2'd1, 1);
        push(8'h12, 2'd2, 1);
        push(8'h13, 2'd3, 1);
        push(8'h14, 2'd0, 1);
        chk("t2_ready_full", {31'd0, cmd_ready}, 0);
        chk("t2_level_full", {29'd0, level}, 4);
        cmd_valid = 1'b1;
        cmd_data  = 8'h15;
        cmd_ch    = 2'd1;
        idle(3);
        chk("t2_ready_held", {31'd0, cmd_ready}, 0);
        chk("t2_level_held", {29'd0, level}, 4);
        chk("t2_write_count", wr_cyc.size(), 2);
        com_end = 4'b0001;
        tick();
        com_end = '0;
        push(8'h15, 2'd1, 1);
        complete_next(2'd1);
        complete_next(2'd2);
        complete_next(2'd3);
        complete_next(2'd0);
        complete_next(2'd1);
        chk("t2_busy_drained", {31'd0, busy}, 0);
        chk("t2_level_drained", {29'd0, level}, 0);

        // retry then error halt
        timeout = 8'd5;
        i0 = wr_cyc.size();
        push(8'hA1, 2'd3, 3);
        push(8'hB2, 2'd1, 1);
        push(8'hC3, 2'd2, 1);
        wait_write("t3_write1");
        tick();
        wait_write("t3_write2");
        tick();
        wait_write("t3_write3");
        idle(4);
        chk("t3_err_before", {31'd0, err}, 0);
        tick();
        chk("t3_err_set", {31'd0, err}, 1);
        chk("t3_err_ch", {30'd0, err_ch}, 3);
        chk("t3_busy_halt", {31'd0, busy}, 1);
        chk("t3_retry_count", wr_cyc.size(), i0 + 3);
        chk("t3_gap12", wr_cyc[i0+1] - wr_cyc[i0], 6);
        chk("t3_gap23", wr_cyc[i0+2] - wr_cyc[i0+1], 6);
        idle(10);
        chk("t3_halt_err", {31'd0, err}, 1);
        chk("t3_halt_level", {29'd0, level}, 2);
        chk("t3_halt_no_write", wr_cyc.size(), i0 + 3);
        timeout = 8'd0;
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("t3_err_clr", {31'd0, err}, 0);
        chk("t3_err_ch_clr", {30'd0, err_ch}, 0);
        chk("t3_clr_w0", {31'd0, write}, 0);
        tick();
        chk("t3_clr_w1", {31'd0, write}, 0);
        tick();
        chk("t3_clr_w2", {31'd0, write}, 1);
        complete_next(2'd1);
        complete_next(2'd2);

        // completion in the same cycle the counter expires
        timeout = 8'd4;
        push(8'hD4, 2'd0, 1);
        push(8'hE5, 2'd1, 1);
        wait_write("t4_write_d");
        i0 = wr_cyc.size();
        idle(3);
        com_end = 4'b0001;
        tick();
        com_end = '0;
        chk("t4_err_clear", {31'd0, err}, 0);
        complete_next(2'd1);
        chk("t4_next_gap", wr_cyc[i0+1] - wr_cyc[i0], 6);
        chk("t4_err_end", {31'd0, err}, 0);

        // completions on other channels are ignored
        timeout = 8'd0;
        push(8'h3C, 2'd1, 1);
        wait_write("t5_write");
        tick();
        com_end = 4'b1001;
        tick();
        com_end = '0;
        n0 = wr_cyc.size();
        idle(3);
        chk("t5_busy_ignored", {31'd0, busy}, 1);
        chk("t5_no_reissue", wr_cyc.size(), n0);
        com_end = 4'b0010;
        tick();
        com_end = '0;
        chk("t5_busy_done", {31'd0, busy}, 0);

        // reset while waiting with three commands queued
        push(8'h61, 2'd2, 1);
        push(8'h72, 2'd3, 1);
        push(8'h83, 2'd0, 1);
        push(8'h94, 2'd1, 1);
        idle(2);
        chk("t6_level_pre", {29'd0, level}, 3);
        chk("t6_busy_pre", {31'd0, busy}, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
        chk("t6_level_rst", {29'd0, level}, 0);
        chk("t6_ready_rst", {31'd0, cmd_ready}, 1);
        chk("t6_busy_rst", {31'd0, busy}, 0);
        chk("t6_write_r0", {31'd0, write}, 0);
        tick();
        chk("t6_write_r1", {31'd0, write}, 0);
        tick();
        chk("t6_write_r2", {31'd0, write}, 0);
        idle(3);
        chk("t6_busy_after", {31'd0, busy}, 0);
        chk("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
